arbiter: RTL and testbench

// - N-client arbiter multiplexing independent read and write channels onto one memory port (or an upstream arbiter).
// - Read data is broadcast to all clients; per-client valid/done strobes mark ownership and completion.

---
 rtl/arbiter_pkg.sv | 40 ++++
 rtl/arbiter_channel.sv | 85 ++++++++
 rtl/arbiter.sv | 77 +++++++
 tb/tb_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and grant helpers for the N-client read/write arbiter.
// Helpers work on a fixed-width client vector; callers zero-extend and truncate.
package arbiter_pkg;

    localparam int MAX_CLIENTS = 64;

    typedef logic [MAX_CLIENTS-1:0] client_vec_t;

    typedef enum logic {
        CH_IDLE,
        CH_BUSY
    } ch_state_t;

    // First requester at or after ptr, wrapping modulo n; returns one-hot.
    function automatic client_vec_t rr_pick(client_vec_t req, int unsigned n, int unsigned ptr);
        client_vec_t pick;
        logic        found;
        int unsigned k;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_CLIENTS; i++) begin
            k = ptr + unsigned'(i);
            if (k >= n) k = k - n;
            if (unsigned'(i) < n && !found && req[k]) begin
                pick[k] = 1'b1;
                found   = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic int unsigned onehot_to_idx(client_vec_t oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_CLIENTS; i++)
            if (oh[i]) idx = idx | unsigned'(i);
        return idx;
    endfunction

endpackage

// File: rtl/arbiter_channel.sv
// One arbitration channel: combinational grant when idle, locked grant until completion.
// Define ARBITER_FIXED_PRIORITY_EN for lowest-index-wins instead of round-robin.
module arbiter_channel
    import arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic                   complete,
    output logic [NUM_CLIENTS-1:0] grant,
    output logic [NUM_CLIENTS-1:0] strobe
);

    localparam int BIT_CLIENTS = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    ch_state_t              state, state_nxt;
    logic [NUM_CLIENTS-1:0] lock_q, lock_nxt;

`ifdef ARBITER_FIXED_PRIORITY_EN
    always_comb begin
        grant     = '0;
        state_nxt = state;
        lock_nxt  = lock_q;
        if (!rst) begin
            if (state == CH_BUSY) grant = lock_q & req;
            else                  grant = NUM_CLIENTS'(rr_pick(client_vec_t'(req), NUM_CLIENTS, 0));
        end
        strobe = grant & {NUM_CLIENTS{complete}};
        if (|grant && !complete) begin
            state_nxt = CH_BUSY;
            lock_nxt  = grant;
        end else begin
            state_nxt = CH_IDLE;
        end
    end
`else
    logic [BIT_CLIENTS-1:0] ptr_q, ptr_nxt;
    int unsigned            win;

    always_comb begin
        grant     = '0;
        state_nxt = state;
        lock_nxt  = lock_q;
        ptr_nxt   = ptr_q;
        win       = 0;
        if (!rst) begin
            if (state == CH_BUSY) grant = lock_q & req;
            else                  grant = NUM_CLIENTS'(rr_pick(client_vec_t'(req), NUM_CLIENTS, 32'(ptr_q)));
        end
        strobe = grant & {NUM_CLIENTS{complete}};
        if (|grant) begin
            if (complete) begin
                // Winner moves to the back of the queue.
                win       = onehot_to_idx(client_vec_t'(grant));
                state_nxt = CH_IDLE;
                ptr_nxt   = (win + 1 >= unsigned'(NUM_CLIENTS)) ? '0 : BIT_CLIENTS'(win + 1);
            end else begin
                state_nxt = CH_BUSY;
                lock_nxt  = grant;
            end
        end else begin
            // Covers a locked client withdrawing: release, pointer untouched.
            state_nxt = CH_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_nxt;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= CH_IDLE;
            lock_q <= '0;
        end else begin
            state  <= state_nxt;
            lock_q <= lock_nxt;
        end
    end

endmodule

// File: rtl/arbiter.sv
// N-client arbiter: independent read and write channels onto one memory port.
// Build option: ARBITER_FIXED_PRIORITY_EN selects fixed priority in both channels.
module arbiter
    import arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS           = 8,
    parameter int ADDR_SIZE             = 16,
    parameter int WRITE_DATA_SIZE       = 32,
    parameter int READ_DATA_SIZE        = 512,
    parameter int HAVE_UPSTREAM_ARBITER = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CLIENTS-1:0]     client_read_en,
    input  logic [ADDR_SIZE-1:0]       client_read_addr  [NUM_CLIENTS],
    input  logic [NUM_CLIENTS-1:0]     client_write_en,
    input  logic [ADDR_SIZE-1:0]       client_write_addr [NUM_CLIENTS],
    input  logic [WRITE_DATA_SIZE-1:0] client_write_data [NUM_CLIENTS],
    input  logic [READ_DATA_SIZE-1:0]  mem_read_data,
    input  logic                       upstream_read_valid,
    input  logic                       upstream_write_done,
    output logic [READ_DATA_SIZE-1:0]  client_read_data,
    output logic [NUM_CLIENTS-1:0]     client_read_valid,
    output logic [NUM_CLIENTS-1:0]     client_write_done,
    output logic                       mem_read_en,
    output logic [ADDR_SIZE-1:0]       mem_read_addr,
    output logic                       mem_write_en,
    output logic [ADDR_SIZE-1:0]       mem_write_addr,
    output logic [WRITE_DATA_SIZE-1:0] mem_write_data
);

    localparam bit NO_UPSTREAM = (HAVE_UPSTREAM_ARBITER == 0);

    logic [NUM_CLIENTS-1:0] client_read_grants;
    logic [NUM_CLIENTS-1:0] client_write_grants;
    logic                   read_complete, write_complete;

    // Without an upstream arbiter the memory finishes in the grant cycle.
    assign read_complete  = upstream_read_valid | NO_UPSTREAM;
    assign write_complete = upstream_write_done | NO_UPSTREAM;

    arbiter_channel #(.NUM_CLIENTS(NUM_CLIENTS)) u_read_ch (
        .clk      (clk),
        .rst      (rst),
        .req      (client_read_en),
        .complete (read_complete),
        .grant    (client_read_grants),
        .strobe   (client_read_valid)
    );

    arbiter_channel #(.NUM_CLIENTS(NUM_CLIENTS)) u_write_ch (
        .clk      (clk),
        .rst      (rst),
        .req      (client_write_en),
        .complete (write_complete),
        .grant    (client_write_grants),
        .strobe   (client_write_done)
    );

    assign client_read_data = mem_read_data;
    assign mem_read_en      = |client_read_grants;
    assign mem_write_en     = |client_write_grants;

    always_comb begin
        mem_read_addr  = '0;
        mem_write_addr = '0;
        mem_write_data = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (client_read_grants[i])  mem_read_addr  = mem_read_addr  | client_read_addr[i];
            if (client_write_grants[i]) begin
                mem_write_addr = mem_write_addr | client_write_addr[i];
                mem_write_data = mem_write_data | client_write_data[i];
            end
        end
    end

endmodule

// File: tb/tb_arbiter.sv
// Directed bench for arbiter: locking, round-robin order, concurrency, withdrawal, reset.
module tb_arbiter;

    localparam int N  = 8;
    localparam int AW = 16;
    localparam int WW = 32;
    localparam int RW = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  client_read_en;
    logic [AW-1:0] client_read_addr  [N];
    logic [N-1:0]  client_write_en;
    logic [AW-1:0] client_write_addr [N];
    logic [WW-1:0] client_write_data [N];
    logic [RW-1:0] mem_read_data;
    logic          upstream_read_valid;
    logic          upstream_write_done;
    logic [RW-1:0] client_read_data;
    logic [N-1:0]  client_read_valid;
    logic [N-1:0]  client_write_done;
    logic          mem_read_en;
    logic [AW-1:0] mem_read_addr;
    logic          mem_write_en;
    logic [AW-1:0] mem_write_addr;
    logic [WW-1:0] mem_write_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] mem_model(logic [AW-1:0] a);
        return {16{a, ~a}};
    endfunction

    assign mem_read_data = mem_model(mem_read_addr);

    arbiter #(
        .NUM_CLIENTS(N), .ADDR_SIZE(AW), .WRITE_DATA_SIZE(WW),
        .READ_DATA_SIZE(RW), .HAVE_UPSTREAM_ARBITER(1)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .client_read_en      (client_read_en),
        .client_read_addr    (client_read_addr),
        .client_write_en     (client_write_en),
        .client_write_addr   (client_write_addr),
        .client_write_data   (client_write_data),
        .mem_read_data       (mem_read_data),
        .upstream_read_valid (upstream_read_valid),
        .upstream_write_done (upstream_write_done),
        .client_read_data    (client_read_data),
        .client_read_valid   (client_read_valid),
        .client_write_done   (client_write_done),
        .mem_read_en         (mem_read_en),
        .mem_read_addr       (mem_read_addr),
        .mem_write_en        (mem_write_en),
        .mem_write_addr      (mem_write_addr),
        .mem_write_data      (mem_write_data)
    );

    task automatic test_reset;
        rst = 1'b1;
        client_read_en = 8'h01;
        client_write_en = 8'h01;
        upstream_read_valid = 1'b1;
        upstream_write_done = 1'b1;
        #1;
        checks++;
        if ({mem_read_en, mem_write_en, client_read_valid, client_write_done} !== 18'h0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b%b rv=%h wd=%h, want all 0",
                     mem_read_en, mem_write_en, client_read_valid, client_write_done);
        end
        checks++;
        if (mem_read_addr !== 16'h0 || mem_write_addr !== 16'h0 || mem_write_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: got ra=%h wa=%h wd=%h, want 0", mem_read_addr, mem_write_addr, mem_write_data);
        end
        @(negedge clk);
        client_read_en = '0;
        client_write_en = '0;
        upstream_read_valid = 1'b0;
        upstream_write_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read_lock;
        @(negedge clk);
        client_read_addr[0] = 16'h7A34;
        client_read_en[0] = 1'b1;
        #1;
        checks++;
        if (mem_read_addr !== 16'h7A34 || mem_read_en !== 1'b1) begin
            errors++;
            $display("FAIL read_addr_zero_latency: got en=%b addr=%h, want 1 7a34", mem_read_en, mem_read_addr);
        end
        checks++;
        if (client_read_data !== mem_model(16'h7A34)) begin
            errors++;
            $display("FAIL read_data_passthru: got %h, want %h", client_read_data[31:0], 32'h7A3485CB);
        end
        checks++;
        if (client_read_valid !== 8'h00 || dut.client_read_grants !== 8'h01) begin
            errors++;
            $display("FAIL read_pending: got valid=%h grant=%h, want 00 01", client_read_valid, dut.client_read_grants);
        end
        @(negedge clk);
        client_read_addr[1] = 16'h83DB;
        client_read_en[1] = 1'b1;
        #1;
        checks++;
        if (dut.client_read_grants !== 8'h01 || client_read_data !== mem_model(16'h7A34)) begin
            errors++;
            $display("FAIL read_no_preempt: got grant=%h data=%h, want 01 7a3485cb",
                     dut.client_read_grants, client_read_data[31:0]);
        end
        @(negedge clk);
        upstream_read_valid = 1'b1;
        #1;
        checks++;
        if (client_read_valid !== 8'h01) begin
            errors++;
            $display("FAIL read_complete0: got valid=%h, want 01", client_read_valid);
        end
        @(negedge clk);
        upstream_read_valid = 1'b0;
        client_read_en[0] = 1'b0;
        #1;
        checks++;
        if (dut.client_read_grants !== 8'h02 || mem_read_addr !== 16'h83DB || client_read_valid !== 8'h00) begin
            errors++;
            $display("FAIL read_next_grant: got grant=%h addr=%h valid=%h, want 02 83db 00",
                     dut.client_read_grants, mem_read_addr, client_read_valid);
        end
        @(negedge clk);
        upstream_read_valid = 1'b1;
        #1;
        checks++;
        if (client_read_valid !== 8'h02) begin
            errors++;
            $display("FAIL read_complete1: got valid=%h, want 02", client_read_valid);
        end
        @(negedge clk);
        upstream_read_valid = 1'b0;
        client_read_en[1] = 1'b0;
    endtask

    task automatic test_write_rr;
        logic [7:0] order [3];
        int         idx   [3];
        order[0] = 8'h01; order[1] = 8'h08; order[2] = 8'h80;
        idx[0] = 0; idx[1] = 3; idx[2] = 7;
        for (int i = 0; i < N; i++) begin
            client_write_addr[i] = 16'h1000 + 16'(i * 16'h111);
            client_write_data[i] = 32'hC0DE_0000 + 32'(i * 32'h0101);
        end
        @(negedge clk);
        client_write_en = 8'h89;
        upstream_write_done = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++;
            if (client_write_done !== order[s] || mem_write_en !== 1'b1) begin
                errors++;
                $display("FAIL write_rr_step%0d: got done=%h en=%b, want %h 1", s, client_write_done, mem_write_en, order[s]);
            end
            checks++;
            if (mem_write_addr !== 16'h1000 + 16'(idx[s] * 16'h111) ||
                mem_write_data !== 32'hC0DE_0000 + 32'(idx[s] * 32'h0101)) begin
                errors++;
                $display("FAIL write_bus_step%0d: got addr=%h data=%h, want client %0d", s, mem_write_addr, mem_write_data, idx[s]);
            end
            @(negedge clk);
            client_write_en[idx[s]] = 1'b0;
        end
        #1;
        checks++;
        if (mem_write_en !== 1'b0 || client_write_done !== 8'h00) begin
            errors++;
            $display("FAIL write_idle: got en=%b done=%h, want 0 00", mem_write_en, client_write_done);
        end
        upstream_write_done = 1'b0;
    endtask

    task automatic test_concurrent;
        @(negedge clk);
        client_read_addr[2] = 16'h2222;
        client_read_en[2] = 1'b1;
        client_write_en[5] = 1'b1;
        upstream_read_valid = 1'b1;
        upstream_write_done = 1'b1;
        #1;
        checks++;
        if (mem_read_en !== 1'b1 || mem_write_en !== 1'b1) begin
            errors++;
            $display("FAIL concurrent_en: got ren=%b wen=%b, want 1 1", mem_read_en, mem_write_en);
        end
        checks++;
        if (client_read_valid !== 8'h04 || client_write_done !== 8'h20) begin
            errors++;
            $display("FAIL concurrent_strobes: got rv=%h wd=%h, want 04 20", client_read_valid, client_write_done);
        end
        checks++;
        if (mem_read_addr !== 16'h2222 || mem_write_addr !== 16'h1555) begin
            errors++;
            $display("FAIL concurrent_addr: got ra=%h wa=%h, want 2222 1555", mem_read_addr, mem_write_addr);
        end
        @(negedge clk);
        client_read_en = '0;
        client_write_en = '0;
        upstream_read_valid = 1'b0;
        upstream_write_done = 1'b0;
    endtask

    task automatic test_withdraw;
        // read pointer now sits at 3
        @(negedge clk);
        client_read_addr[4] = 16'h4444;
        client_read_en[4] = 1'b1;
        #1;
        checks++;
        if (dut.client_read_grants !== 8'h10) begin
            errors++;
            $display("FAIL withdraw_grant: got %h, want 10", dut.client_read_grants);
        end
        @(negedge clk);
        client_read_en[4] = 1'b0;
        upstream_read_valid = 1'b1;
        #1;
        checks++;
        if (client_read_valid !== 8'h00 || mem_read_en !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_no_strobe: got valid=%h en=%b, want 00 0", client_read_valid, mem_read_en);
        end
        @(negedge clk);
        upstream_read_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        client_read_addr[1] = 16'h1111;
        client_read_addr[6] = 16'h6666;
        client_read_en = 8'h42;
        #1;
        checks++;
        if (dut.client_read_grants !== 8'h40 || mem_read_addr !== 16'h6666) begin
            errors++;
            $display("FAIL pre_reset_grant: got grant=%h addr=%h, want 40 6666", dut.client_read_grants, mem_read_addr);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        upstream_read_valid = 1'b1;
        #1;
        checks++;
        if (dut.client_read_grants !== 8'h00 || mem_read_en !== 1'b0 || client_read_valid !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_drop: got grant=%h en=%b valid=%h, want 00 0 00",
                     dut.client_read_grants, mem_read_en, client_read_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        upstream_read_valid = 1'b0;
        #1;
        checks++;
        if (dut.client_read_grants !== 8'h02 || mem_read_addr !== 16'h1111) begin
            errors++;
            $display("FAIL post_reset_rearb: got grant=%h addr=%h, want 02 1111", dut.client_read_grants, mem_read_addr);
        end
        @(negedge clk);
        client_read_en = '0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            client_read_addr[i]  = '0;
            client_write_addr[i] = '0;
            client_write_data[i] = '0;
        end
        test_reset();
        test_read_lock();
        test_write_rr();
        test_concurrent();
        test_withdraw();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
